avalon_register_arbiter: RTL and testbench
==========================================

AVALON_REGISTER_ARBITER -- requirements
Module: avalon_register_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 2, number of Avalon masters sharing one register slave (2..8).
REQ-002 SHALL have parameter BUSWIDTH, default 32, data width.
REQ-003 SHALL have parameter ADDRESSWIDTH, default 4, register address width.
REQ-004 SHALL have parameter LATENCY, default 1, fixed slave read latency in cycles (1..4).
REQ-005 clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 m_read  input  REQUESTERS  per-master read request, held until accepted.
REQ-008 m_write  input  REQUESTERS  per-master write request, held until accepted.
REQ-009 m_address  input  REQUESTERS x ADDRESSWIDTH  per-master address.
REQ-010 m_data_in  input  REQUESTERS x BUSWIDTH  per-master write data.
REQ-011 m_waitrequest  output  REQUESTERS  low for exactly the accept cycle of that master.
REQ-012 m_read_valid  output  REQUESTERS  read data valid, owner bit only.
REQ-013 m_data_out  output  BUSWIDTH  read data, shared by all masters.
REQ-014 s_read, s_write  output  1 each  slave command strobes, one cycle per transaction.
REQ-015 s_address  output  ADDRESSWIDTH; s_data_in  output  BUSWIDTH  slave command fields.
REQ-016 s_read_valid  input  1; s_data_out  input  BUSWIDTH  slave read response.
REQ-017 rd_timeout  output  1  one-cycle pulse when a read response is missing.

Function
REQ-018 FSM states IDLE, ISSUE, RDWAIT; owner register holds granted master index.
REQ-019 IDLE: any m_read|m_write bit set -> latch winner into owner, go ISSUE; no slave strobe.
REQ-020 ISSUE: drive s_* from owner, m_waitrequest[owner]=0; write -> IDLE, read -> RDWAIT.
REQ-021 ISSUE with owner request dropped: no strobe, waitrequest stays high, -> IDLE.
REQ-022 m_read and m_write both set on owner: write performed, read discarded.
REQ-023 RDWAIT: m_read_valid[owner]=s_read_valid, m_data_out=s_data_out; on s_read_valid -> IDLE.
REQ-024 RDWAIT cycle counter starts at 1; counter reaching LATENCY+2 without s_read_valid -> rd_timeout pulse, -> IDLE.
REQ-025 s_read_valid outside RDWAIT is ignored; no m_read_valid bit asserted.
REQ-026 Latency: request in IDLE at cycle N -> slave strobe and accept at N+1; read data at N+1+LATENCY.
REQ-027 Write throughput: one transaction per 2 cycles; at most one read outstanding.
REQ-028 m_waitrequest bits not accepted that cycle are 1; all s_* strobes 0 outside ISSUE.

Reset
REQ-029 Reset: state IDLE, owner 0, round-robin pointer REQUESTERS-1, counter 0.
REQ-030 During reset: m_waitrequest all 1, m_read_valid 0, s_read/s_write 0, rd_timeout 0, data outputs 0.
REQ-031 Reset mid-read: pending response discarded; no m_read_valid after reset release.

Configuration
REQ-032 Macro AVALON_ARB_ROUND_ROBIN_EN defined: winner = first requester after last owner (wrapping), pointer updated on each accept.
REQ-033 Macro undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-034 Master0 write addr 3 data 0xA5A5A5A5 -> s_write one cycle, s_address 3, m_waitrequest[0] low same cycle.
REQ-035 LATENCY=2, master1 read addr 5, slave returns 0x12345678 -> m_read_valid[1] 3 cycles after request, m_read_valid[0] 0.
REQ-036 Both masters writing continuously, RR enabled -> grants alternate 0,1,0,1; macro off -> master0 only.
REQ-037 Read with slave silent -> rd_timeout pulse at RDWAIT count LATENCY+2, FSM back to IDLE, next request served.
REQ-038 Reset asserted in RDWAIT, slave valid after release -> no m_read_valid, all m_waitrequest 1 during reset.

Source files
------------

// File: rtl/avalon_register_arbiter_if.sv
// rtl/avalon_register_arbiter_if.sv - bus bundle between Avalon masters, the arbiter and one register slave
// Purpose: groups every master-side and slave-side signal of the register arbiter.
// Ports (arbiter view, modport master):
//   inputs : m_read, m_write, m_address, m_data_in, s_read_valid, s_data_out
//   outputs: m_waitrequest, m_read_valid, m_data_out, s_read, s_write,
//            s_address, s_data_in, rd_timeout
// Modport slave is the mirror image, used by the surrounding environment.
interface avalon_register_arbiter_if #(
    parameter int REQUESTERS   = 2,
    parameter int BUSWIDTH     = 32,
    parameter int ADDRESSWIDTH = 4
);
    logic [REQUESTERS-1:0]                   m_read;
    logic [REQUESTERS-1:0]                   m_write;
    logic [REQUESTERS-1:0][ADDRESSWIDTH-1:0] m_address;
    logic [REQUESTERS-1:0][BUSWIDTH-1:0]     m_data_in;
    logic [REQUESTERS-1:0]                   m_waitrequest;
    logic [REQUESTERS-1:0]                   m_read_valid;
    logic [BUSWIDTH-1:0]                     m_data_out;
    logic                                    s_read;
    logic                                    s_write;
    logic [ADDRESSWIDTH-1:0]                 s_address;
    logic [BUSWIDTH-1:0]                     s_data_in;
    logic                                    s_read_valid;
    logic [BUSWIDTH-1:0]                     s_data_out;
    logic                                    rd_timeout;

    modport master (
        input  m_read, m_write, m_address, m_data_in, s_read_valid, s_data_out,
        output m_waitrequest, m_read_valid, m_data_out,
               s_read, s_write, s_address, s_data_in, rd_timeout
    );

    modport slave (
        output m_read, m_write, m_address, m_data_in, s_read_valid, s_data_out,
        input  m_waitrequest, m_read_valid, m_data_out,
               s_read, s_write, s_address, s_data_in, rd_timeout
    );
endinterface

// File: rtl/avalon_register_arbiter.sv
// rtl/avalon_register_arbiter.sv - shares one Avalon register slave between several masters
// Purpose: grants one master at a time, issues a single-cycle slave command and
//          routes the fixed-latency read response back to the granted master.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - avalon_register_arbiter_if.master (master requests, slave command,
//           slave response, rd_timeout pulse)
// Configuration: define AVALON_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//                otherwise the lowest-index requester always wins.
module avalon_register_arbiter #(
    parameter int REQUESTERS   = 2,
    parameter int BUSWIDTH     = 32,
    parameter int ADDRESSWIDTH = 4,
    parameter int LATENCY      = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    avalon_register_arbiter_if.master        bus
);
    localparam int OW = $clog2(REQUESTERS);
    localparam int CW = $clog2(LATENCY + 3);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [OW-1:0]   winner;
    logic [REQUESTERS-1:0] req;

    assign req = bus.m_read | bus.m_write;

`ifdef AVALON_ARB_ROUND_ROBIN_EN
    logic [OW-1:0] ptr_q, ptr_d;
    logic [OW-1:0] cand;

    // Scan from the farthest candidate towards the nearest one after the
    // pointer, so the nearest requester is the last (winning) assignment.
    always_comb begin
        winner = ptr_q;
        cand   = '0;
        for (int i = REQUESTERS; i >= 1; i--) begin
            cand = OW'((int'(ptr_q) + i) % REQUESTERS);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = OW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        bus.m_waitrequest = '1;
        bus.m_read_valid  = '0;
        bus.m_data_out    = '0;
        bus.s_read        = 1'b0;
        bus.s_write       = 1'b0;
        bus.s_address     = '0;
        bus.s_data_in     = '0;
        bus.rd_timeout    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                // A dropped request falls through with no strobe and no accept.
                state_d = IDLE;
                cnt_d   = '0;
                if (bus.m_write[owner_q]) begin
                    // Write wins when both strobes are up; the read is discarded.
                    bus.s_write                = 1'b1;
                    bus.s_address              = bus.m_address[owner_q];
                    bus.s_data_in              = bus.m_data_in[owner_q];
                    bus.m_waitrequest[owner_q] = 1'b0;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
                    ptr_d = owner_q;
`endif
                end else if (bus.m_read[owner_q]) begin
                    bus.s_read                 = 1'b1;
                    bus.s_address              = bus.m_address[owner_q];
                    bus.m_waitrequest[owner_q] = 1'b0;
                    state_d                    = RDWAIT;
                    cnt_d                      = CW'(1);
`ifdef AVALON_ARB_ROUND_ROBIN_EN
                    ptr_d = owner_q;
`endif
                end
            end

            RDWAIT: begin
                bus.m_read_valid[owner_q] = bus.s_read_valid;
                bus.m_data_out            = bus.s_data_out;
                if (bus.s_read_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    bus.rd_timeout = 1'b1;
                    state_d        = IDLE;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
            ptr_q   <= OW'(REQUESTERS - 1);
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_avalon_register_arbiter.sv
// tb/tb_avalon_register_arbiter.sv - self-checking bench for avalon_register_arbiter
module tb_avalon_register_arbiter;
    localparam int R   = 2;
    localparam int BW  = 32;
    localparam int AW  = 4;
    localparam int LAT = 2;
    localparam logic [6:0] QUIET = 7'b1100000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avalon_register_arbiter_if #(.REQUESTERS(R), .BUSWIDTH(BW), .ADDRESSWIDTH(AW)) bus ();

    avalon_register_arbiter #(
        .REQUESTERS(R), .BUSWIDTH(BW), .ADDRESSWIDTH(AW), .LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int           master;
        bit           wr;
        bit           rd;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        bit           silent;
        logic [BW-1:0] rdata;
        logic [R-1:0] exp_wait;
        bit           exp_sw;
        bit           exp_sr;
        logic [R-1:0] exp_rv;
        bit           exp_to;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] outs();
        return {bus.m_waitrequest, bus.m_read_valid, bus.s_read, bus.s_write, bus.rd_timeout};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_read       = '0;
        bus.m_write      = '0;
        bus.m_address    = '0;
        bus.m_data_in    = '0;
        bus.s_read_valid = 1'b0;
        bus.s_data_out   = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [6:0] e;
        int last;
        bus.m_write[v.master]   = v.wr;
        bus.m_read[v.master]    = v.rd;
        bus.m_address[v.master] = v.addr;
        bus.m_data_in[v.master] = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d_request", idx), outs(), QUIET);
        next();
        @(negedge clk);
        chk($sformatf("v%0d_accept", idx), outs(), {v.exp_wait, 2'b00, v.exp_sr, v.exp_sw, 1'b0});
        chk($sformatf("v%0d_addr", idx), bus.s_address, v.addr);
        if (v.exp_sw) chk($sformatf("v%0d_wdata", idx), bus.s_data_in, v.wdata);
        next();
        bus.m_write = '0;
        bus.m_read  = '0;
        if (v.exp_sr) begin
            last = v.silent ? LAT + 3 : LAT + 1;
            for (int k = 2; k <= last; k++) begin
                bus.s_read_valid = (!v.silent && k == LAT + 1);
                bus.s_data_out   = bus.s_read_valid ? v.rdata : 32'h0BAD_0000;
                @(negedge clk);
                e = QUIET;
                if (!v.silent && k == LAT + 1) e[4:3] = v.exp_rv;
                if (v.silent && k == LAT + 3) e[0] = v.exp_to;
                chk($sformatf("v%0d_rdwait_k%0d", idx, k), outs(), e);
                if (e[4:3] != 2'b00) chk($sformatf("v%0d_rdata", idx), bus.m_data_out, v.rdata);
                next();
                bus.s_read_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d_back_idle", idx), outs(), QUIET);
        next();
    endtask

    function automatic int exp_grant(input int k);
`ifdef AVALON_ARB_ROUND_ROBIN_EN
        return k % 2;
`else
        return 0 * k;
`endif
    endfunction

    // Reference-model state for the random phase
    bit            pend_wr[R];
    bit            pend_rd[R];
    logic [AW-1:0] pend_addr[R];
    logic [BW-1:0] pend_data[R];

    function automatic int pick(input int last_owner);
        int m;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= R; k++) begin
            m = (last_owner + k) % R;
            if (pend_wr[m] || pend_rd[m]) return m;
        end
`else
        m = last_owner;
        for (int k = 0; k < R; k++) if (pend_wr[k] || pend_rd[k]) return k;
`endif
        return -1;
    endfunction

    initial begin
        int grants[$];
        int cyc, free_at, g_cyc, g_idx, r_idx, rsp_cyc, to_cyc, last_owner, accepted, kind;
        bit rd_busy, any;
        logic [R-1:0]  exp_wait, exp_rv;
        logic          exp_sr, exp_sw, exp_to;
        logic [AW-1:0] exp_addr;
        logic [BW-1:0] exp_data, rsp_data;

        vecs[0] = '{0, 1'b1, 1'b0, 4'h3, 32'hA5A5A5A5, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{1, 1'b0, 1'b1, 4'h5, 32'h0,        1'b0, 32'h12345678, 2'b01, 1'b0, 1'b1, 2'b10, 1'b0};
        vecs[2] = '{1, 1'b1, 1'b0, 4'hF, 32'h0,        1'b0, 32'h0,        2'b01, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[3] = '{0, 1'b0, 1'b1, 4'h9, 32'h0,        1'b1, 32'h0,        2'b10, 1'b0, 1'b1, 2'b00, 1'b1};
        vecs[4] = '{0, 1'b1, 1'b1, 4'h7, 32'hDEADBEEF, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[5] = '{1, 0, 1'b1, 4'h0, 32'h0,           1'b0, 32'hFFFFFFFF, 2'b01, 1'b0, 1'b1, 2'b10, 1'b0};

        // Reset state, with masters requesting to show nothing leaks through
        reset = 1'b1;
        idle_inputs();
        bus.m_write = '1;
        bus.s_read_valid = 1'b1;
        bus.s_data_out = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        chk("reset_outs", outs(), QUIET);
        chk("reset_dout", bus.m_data_out, 0);
        chk("reset_saddr", bus.s_address, 0);
        chk("reset_sdata", bus.s_data_in, 0);
        next();
        idle_inputs();
        reset = 1'b0;

        // Both masters writing continuously
        bus.m_write = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int m = 0; m < R; m++) if (!bus.m_waitrequest[m]) grants.push_back(m);
            next();
        end
        bus.m_write = '0;
        chk("cont_grant_count", grants.size(), 4);
        for (int k = 0; k < grants.size() && k < 4; k++)
            chk($sformatf("cont_grant_%0d", k), grants[k], exp_grant(k));
        @(negedge clk);
        next();

        // Request dropped while in ISSUE
        bus.m_write[0] = 1'b1;
        @(negedge clk);
        chk("drop_request", outs(), QUIET);
        next();
        bus.m_write = '0;
        @(negedge clk);
        chk("drop_issue", outs(), QUIET);
        next();
        @(negedge clk);
        chk("drop_idle", outs(), QUIET);
        // Stray slave response while idle
        bus.s_read_valid = 1'b1;
        bus.s_data_out = 32'h55AA55AA;
        #1;
        chk("stray_valid_idle", outs(), QUIET);
        next();
        idle_inputs();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset asserted while waiting for read data
        bus.m_read[1] = 1'b1;
        bus.m_address[1] = 4'h2;
        next();
        next();
        bus.m_read = '0;
        reset = 1'b1;
        bus.s_read_valid = 1'b1;
        bus.s_data_out = 32'h77777777;
        @(negedge clk);
        chk("midread_reset_outs", outs(), QUIET);
        chk("midread_reset_dout", bus.m_data_out, 0);
        next();
        reset = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            chk($sformatf("after_reset_c%0d", c), outs(), QUIET);
            next();
        end
        idle_inputs();

        // Randomized phase against a transaction-schedule model
        reset = 1'b1;
        next();
        reset = 1'b0;
        for (int m = 0; m < R; m++) begin
            pend_wr[m] = 0; pend_rd[m] = 0; pend_addr[m] = '0; pend_data[m] = '0;
        end
        free_at = 0; g_cyc = -1; g_idx = 0; r_idx = 0; rsp_cyc = -1; to_cyc = -1;
        last_owner = R - 1; rd_busy = 0; rsp_data = '0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < R; m++) begin
                if (!pend_wr[m] && !pend_rd[m] && $urandom_range(0, 3) == 0) begin
                    kind = $urandom_range(0, 4);
                    pend_wr[m]   = (kind <= 1) || (kind == 4);
                    pend_rd[m]   = (kind >= 2);
                    pend_addr[m] = AW'($urandom);
                    pend_data[m] = $urandom;
                end
                bus.m_write[m]   = pend_wr[m];
                bus.m_read[m]    = pend_rd[m];
                bus.m_address[m] = pend_addr[m];
                bus.m_data_in[m] = pend_data[m];
            end
            exp_wait = '1; exp_rv = '0; exp_sr = 0; exp_sw = 0; exp_to = 0;
            exp_addr = '0; exp_data = '0; accepted = -1;
            if (cyc >= free_at) rd_busy = 0;
            any = 0;
            for (int m = 0; m < R; m++) any |= pend_wr[m] | pend_rd[m];
            if (cyc == g_cyc) begin
                accepted = g_idx;
                last_owner = g_idx;
                exp_wait[g_idx] = 1'b0;
                exp_addr = pend_addr[g_idx];
                if (pend_wr[g_idx]) begin
                    exp_sw = 1; exp_data = pend_data[g_idx]; free_at = cyc + 1;
                end else begin
                    exp_sr = 1; rd_busy = 1; r_idx = g_idx;
                    if ($urandom_range(0, 5) != 0) begin
                        rsp_cyc = cyc + LAT; rsp_data = $urandom; free_at = rsp_cyc + 1;
                    end else begin
                        to_cyc = cyc + LAT + 2; free_at = to_cyc + 1;
                    end
                end
            end else if (cyc >= free_at && any) begin
                g_idx = pick(last_owner);
                g_cyc = cyc + 1;
                free_at = cyc + 2;
            end
            if (cyc == rsp_cyc) begin
                bus.s_read_valid = 1'b1; bus.s_data_out = rsp_data; exp_rv[r_idx] = 1'b1;
            end else if (!rd_busy && $urandom_range(0, 5) == 0) begin
                bus.s_read_valid = 1'b1; bus.s_data_out = $urandom;
            end else begin
                bus.s_read_valid = 1'b0; bus.s_data_out = $urandom;
            end
            if (cyc == to_cyc) exp_to = 1;
            @(negedge clk);
            chk($sformatf("rand_c%0d_outs", cyc), outs(), {exp_wait, exp_rv, exp_sr, exp_sw, exp_to});
            if (exp_sr || exp_sw) chk($sformatf("rand_c%0d_addr", cyc), bus.s_address, exp_addr);
            if (exp_sw) chk($sformatf("rand_c%0d_wdata", cyc), bus.s_data_in, exp_data);
            if (exp_rv != '0) chk($sformatf("rand_c%0d_rdata", cyc), bus.m_data_out, rsp_data);
            if (accepted >= 0) begin
                pend_wr[accepted] = 0;
                pend_rd[accepted] = 0;
            end
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
